// File: rtl/perf_dump_ctrl.sv
// Performance counter readout: snapshots six counters in one cycle and streams them out over valid/ready.
// Optional PERF_DUMP_AUTO_CLEAR_EN adds a CLEAR state that pulses cnt_clear together with done.
module perf_dump_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dump_req,
    input  logic [CNT_W-1:0] cnt_instr,
    input  logic [CNT_W-1:0] cnt_load,
    input  logic [CNT_W-1:0] cnt_store,
    input  logic [CNT_W-1:0] cnt_alu,
    input  logic [CNT_W-1:0] cnt_ctrl,
    input  logic [CNT_W-1:0] cnt_cycles,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_data,
    output logic [2:0]       out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             cnt_clear,
    output logic [7:0]       dump_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
    localparam logic [1:0] ST_CLEAR = 2'd2;
`endif
    localparam logic [2:0] LAST_IDX = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [7:0]       count_q, count_d;
    logic             capture;
    logic [CNT_W-1:0] shadow_q [6];
`ifdef PERF_DUMP_AUTO_CLEAR_EN
    logic             clr_q, clr_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        count_d = count_q;
        capture = 1'b0;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
        clr_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
                        clr_d   = 1'b1;
                        state_d = ST_CLEAR;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef PERF_DUMP_AUTO_CLEAR_EN
            // done/cnt_clear are already registered high for this cycle; requests here are dropped
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
            count_q <= 8'd0;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
            clr_q   <= 1'b0;
`endif
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            count_q <= count_d;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
            clr_q   <= clr_d;
`endif
            // Shadow is written only on the accepting edge, so counter activity during SEND is invisible
            if (capture) begin
                shadow_q[0] <= cnt_instr;
                shadow_q[1] <= cnt_load;
                shadow_q[2] <= cnt_store;
                shadow_q[3] <= cnt_alu;
                shadow_q[4] <= cnt_ctrl;
                shadow_q[5] <= cnt_cycles;
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == ST_SEND) begin
            case (idx_q)
                3'd0:    out_data = shadow_q[0];
                3'd1:    out_data = shadow_q[1];
                3'd2:    out_data = shadow_q[2];
                3'd3:    out_data = shadow_q[3];
                3'd4:    out_data = shadow_q[4];
                3'd5:    out_data = shadow_q[5];
                default: out_data = '0;
            endcase
        end
    end

    assign out_valid  = (state_q == ST_SEND);
    assign out_index  = out_valid ? idx_q : 3'd0;
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign dump_count = count_q;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
    assign cnt_clear  = clr_q;
`else
    assign cnt_clear  = 1'b0;
`endif

endmodule

// File: tb/tb_perf_dump_ctrl.sv
// Randomized self-checking bench for perf_dump_ctrl against a word-list / dump-count reference model.
module tb_perf_dump_ctrl;

    localparam int CNT_W = 16;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
    localparam bit EXP_CLR = 1'b1;
`else
    localparam bit EXP_CLR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             dump_req = 1'b0;
    logic [CNT_W-1:0] cnt_instr = '0, cnt_load = '0, cnt_store = '0;
    logic [CNT_W-1:0] cnt_alu = '0, cnt_ctrl = '0, cnt_cycles = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [CNT_W-1:0] out_data;
    logic [2:0]       out_index;
    logic             out_last, busy, done, cnt_clear;
    logic [7:0]       dump_count;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_w [6];
    logic [7:0]       exp_count = 8'd0;

    perf_dump_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .dump_req(dump_req),
        .cnt_instr(cnt_instr), .cnt_load(cnt_load), .cnt_store(cnt_store),
        .cnt_alu(cnt_alu), .cnt_ctrl(cnt_ctrl), .cnt_cycles(cnt_cycles),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
        .cnt_clear(cnt_clear), .dump_count(dump_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_counters();
        cnt_instr  = exp_w[0];
        cnt_load   = exp_w[1];
        cnt_store  = exp_w[2];
        cnt_alu    = exp_w[3];
        cnt_ctrl   = exp_w[4];
        cnt_cycles = exp_w[5];
    endtask

    task automatic churn_counters();
        cnt_instr  = CNT_W'($urandom);
        cnt_load   = CNT_W'($urandom);
        cnt_store  = CNT_W'($urandom);
        cnt_alu    = CNT_W'($urandom);
        cnt_ctrl   = CNT_W'($urandom);
        cnt_cycles = CNT_W'($urandom);
    endtask

    task automatic random_words();
        for (int i = 0; i < 6; i++) exp_w[i] = CNT_W'($urandom);
    endtask

    // Requests one dump of exp_w and follows it word by word to the done cycle.
    task automatic run_dump(input int stall_pct, input int stall_at, input bit poke,
                            input bit churn, input bit b2b, input string tag);
        int k, cyc, stalls;
        bit rdy;
        drive_counters();
        dump_req  = 1'b1;
        out_ready = 1'b0;
        step();
        dump_req = 1'b0;
        if (churn) churn_counters();
        k = 0; cyc = 0; stalls = 0;
        while (k < 6) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
                begin errors++; $display("FAIL %s ctrl word%0d: valid=%b busy=%b done=%b, required 1 1 0", tag, k, out_valid, busy, done); end
            checks++;
            if (out_index !== 3'(k))
                begin errors++; $display("FAIL %s index: got %0d, required %0d", tag, out_index, k); end
            checks++;
            if (out_data !== exp_w[k])
                begin errors++; $display("FAIL %s data word%0d: got %h, required %h", tag, k, out_data, exp_w[k]); end
            checks++;
            if (out_last !== (k == 5))
                begin errors++; $display("FAIL %s last word%0d: got %b, required %b", tag, k, out_last, (k == 5)); end
            rdy = ($urandom_range(99) >= 32'(stall_pct));
            if (k == stall_at && stalls < 5) begin rdy = 1'b0; stalls++; end
            out_ready = rdy;
            if (poke) dump_req = $urandom_range(1) == 1;
            if (churn) churn_counters();
            step();
            cyc++;
            if (rdy) k++;
            if (cyc > 400) begin
                errors++;
                $display("FAIL %s timeout: %0d words after %0d cycles, required 6", tag, k, cyc);
                dump_req = 1'b0; out_ready = 1'b0;
                return;
            end
        end
        exp_count = exp_count + 8'd1;
        dump_req  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL %s done cycle: done=%b valid=%b, required 1 0", tag, done, out_valid); end
        checks++;
        if (dump_count !== exp_count)
            begin errors++; $display("FAIL %s dump_count: got %0d, required %0d", tag, dump_count, exp_count); end
        checks++;
        if (cnt_clear !== EXP_CLR || busy !== EXP_CLR)
            begin errors++; $display("FAIL %s clear/busy in done cycle: got %b %b, required %b %b", tag, cnt_clear, busy, EXP_CLR, EXP_CLR); end
        if (stall_pct == 0 && stall_at < 0) begin
            checks++;
            if (cyc != 6)
                begin errors++; $display("FAIL %s length: got %0d valid cycles, required 6", tag, cyc); end
        end
        if (!b2b) begin
            step();
            checks++;
            if (done !== 1'b0 || cnt_clear !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
                begin errors++; $display("FAIL %s after done: done=%b clr=%b busy=%b valid=%b, required 0 0 0 0", tag, done, cnt_clear, busy, out_valid); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || cnt_clear !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL reset ctrl: valid=%b last=%b done=%b clr=%b busy=%b, required all 0", out_valid, out_last, done, cnt_clear, busy); end
        checks++;
        if (out_data !== '0 || out_index !== 3'd0 || dump_count !== 8'd0)
            begin errors++; $display("FAIL reset data: data=%h idx=%0d count=%0d, required 0 0 0", out_data, out_index, dump_count); end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL idle hold: busy=%b valid=%b, required 0 0", busy, out_valid); end
        exp_count = 8'd0;
    endtask

    task automatic test_basic();
        exp_w[0] = 16'h0010; exp_w[1] = 16'h0004; exp_w[2] = 16'h0003;
        exp_w[3] = 16'h0007; exp_w[4] = 16'h0002; exp_w[5] = 16'h0040;
        run_dump(0, -1, 1'b0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        exp_w[0] = 16'h0010; exp_w[1] = 16'h0004; exp_w[2] = 16'h0003;
        exp_w[3] = 16'h0007; exp_w[4] = 16'h0002; exp_w[5] = 16'h0040;
        run_dump(0, 2, 1'b0, 1'b1, 1'b0, "backpressure");
        for (int n = 0; n < 4; n++) begin
            random_words();
            run_dump(40, int'($urandom_range(5)), 1'b0, 1'b1, 1'b0, "bp_rand");
        end
    endtask

    task automatic test_busy_ignore();
        for (int n = 0; n < 4; n++) begin
            random_words();
            run_dump(25, -1, 1'b1, 1'b1, 1'b0, "busy_ignore");
        end
    endtask

    task automatic test_back_to_back();
        random_words();
        run_dump(0, -1, 1'b0, 1'b0, 1'b1, "b2b_first");
        random_words();
        drive_counters();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
`ifdef PERF_DUMP_AUTO_CLEAR_EN
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL b2b ignored in CLEAR: busy=%b valid=%b, required 0 0", busy, out_valid); end
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL b2b stays idle: busy=%b valid=%b, required 0 0", busy, out_valid); end
`else
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd0 || out_data !== exp_w[0])
            begin errors++; $display("FAIL b2b restart: valid=%b idx=%0d data=%h, required 1 0 %h", out_valid, out_index, out_data, exp_w[0]); end
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        checks++;
        if (done !== 1'b1 || dump_count !== exp_count)
            begin errors++; $display("FAIL b2b second done: done=%b count=%0d, required 1 %0d", done, dump_count, exp_count); end
        step();
`endif
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        random_words();
        drive_counters();
        dump_req = 1'b1;
        step();
        dump_req  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        checks++;
        if (out_index !== 3'd3 || out_data !== exp_w[3])
            begin errors++; $display("FAIL reset_mid pre: idx=%0d data=%h, required 3 %h", out_index, out_data, exp_w[3]); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_count = 8'd0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dump_count !== 8'd0 || out_data !== '0)
            begin errors++; $display("FAIL reset_mid: valid=%b busy=%b count=%0d data=%h, required 0 0 0 0", out_valid, busy, dump_count, out_data); end
        saw_done = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (done !== 1'b0 || cnt_clear !== 1'b0) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done)
            begin errors++; $display("FAIL reset_mid done: got a done/clear pulse, required none"); end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 256; n++) begin
            random_words();
            run_dump(0, -1, 1'b0, 1'b0, 1'b0, "wrap");
        end
        checks++;
        if (dump_count !== 8'd0)
            begin errors++; $display("FAIL wrap: dump_count %0d, required 0", dump_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_dump_ctrl.md
# perf_dump_ctrl

Readout controller for the processor's performance counter bank. On request it snapshots the six 16-bit counters (instructions, loads, stores, ALU, controls, cycles) into shadow registers in a single cycle. It then streams the six words out over a valid/ready port in fixed order. It sits between the performance counter bank and the debug/host read path, and can optionally clear the counters once a dump completes.

## Interface
Parameters:
- CNT_W, default 16: width of each counter word.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- dump_req  in  1  request a snapshot and dump; sampled only in IDLE.
- cnt_instr  in  CNT_W  total instructions counter.
- cnt_load  in  CNT_W  total loads counter.
- cnt_store  in  CNT_W  total stores counter.
- cnt_alu  in  CNT_W  total ALU counter.
- cnt_ctrl  in  CNT_W  total controls counter.
- cnt_cycles  in  CNT_W  clock cycles counter.
- out_valid  out  1  out_data/out_index hold a valid word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  CNT_W  current shadow word.
- out_index  out  3  word index, 0..5.
- out_last  out  1  high with index 5.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the final word is accepted.
- cnt_clear  out  1  one-cycle clear pulse to the counter bank (see Configuration).
- dump_count  out  8  number of completed dumps, wraps 255→0.

## Operation
- States:
  - IDLE
  - SEND
  - CLEAR (exists only with the macro).
- IDLE with dump_req=1 at the edge:
  - all six inputs are captured into the shadow registers;
  - idx is set to 0;
  - the state goes to SEND.
- IDLE with dump_req=0: no change.
- SEND:
  - out_valid=1;
  - out_data = shadow[idx];
  - out_index = idx;
  - out_last = (idx==5).
- Word order: 0 instr, 1 load, 2 store, 3 alu, 4 ctrl, 5 cycles.
- Handshake: a transfer occurs at an edge where out_valid && out_ready.
  - While out_ready=0, out_data, out_index and out_last hold stable. The shadow registers are never updated during SEND.
  - A transfer with idx<5 increments idx.
  - A transfer with idx==5 ends the dump: done=1 next cycle, and dump_count increments on that same edge. The next state depends on Configuration.
- dump_req while busy is ignored, not queued.
- The shadow captures the counter values present at the accepting edge. Later counter activity does not affect the dump.
- Reset values:
  - state IDLE;
  - out_valid, out_last, done, cnt_clear, busy = 0;
  - out_data, out_index, idx, dump_count and all shadow registers = 0.

## Timing
- Request to first valid word: 1 cycle (out_valid is high the cycle after the accepting edge).
- With out_ready tied high, the minimum dump length is 6 cycles of out_valid, and done appears in the 7th cycle.
- done and cnt_clear are registered, one cycle wide, and are asserted in the same cycle.
- Without the macro the state is IDLE during the done cycle, so a dump_req in that cycle is accepted (back-to-back dumps are possible).
- With the macro the state is CLEAR during the done cycle, so dump_req is ignored. IDLE resumes on the following cycle.
- Reset (reset=0) mid-dump:
  - aborts immediately at the next edge;
  - every output goes to its reset value;
  - no done, no cnt_clear;
  - dump_count is cleared.

## Configuration
- Macro: PERF_DUMP_AUTO_CLEAR_EN.
- Defined:
  - the final transfer moves the state to CLEAR;
  - in CLEAR, cnt_clear=1 and done=1 for one cycle, then the state goes to IDLE.
- Undefined:
  - the CLEAR state and its logic are not compiled;
  - cnt_clear is tied 0;
  - the final transfer moves the state directly to IDLE with done=1.

## Test plan
- Basic dump: after reset, drive the inputs to 0x0010, 0x0004, 0x0003, 0x0007, 0x0002, 0x0040, pulse dump_req, and hold out_ready=1 → words appear in that order at indices 0..5 on consecutive cycles, out_last only with index 5, done in the 7th cycle, dump_count=1.
- Backpressure and snapshot isolation: hold out_ready=0 for 5 cycles on index 2 while the inputs change → out_data stays at the captured 0x0003, and all later words still show the captured values.
- Busy ignore: pulse dump_req during SEND → no restart, exactly 6 words, dump_count increments by 1.
- Reset mid-dump: assert reset=0 at index 3 → the next cycle shows out_valid=0, busy=0, dump_count=0, and done never pulses.
- Auto-clear, macro defined: complete a dump → cnt_clear=1 for exactly one cycle, coincident with done. Undefined: cnt_clear stays 0 throughout, and a dump_req in the done cycle starts a new dump one cycle later.
- Wrap: complete 256 dumps → dump_count returns to 0.
